// File: rtl/counter_pkg.sv
// Shared encodings and helpers for the multi-digit modulo-M up/down counter.
package counter_pkg;

  localparam int DIGIT_W = 4;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_DOWN  = 2'b01,
    ST_UP    = 2'b10
  } state_t;

  // Any loaded digit outside 0..mod-1 is pulled down to mod-1.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d, input int mod);
    return (int'(d) >= mod) ? DIGIT_W'(mod - 1) : d;
  endfunction

endpackage

// File: rtl/mod_digit_cell.sv
// One radix-MOD digit with synchronous load and ripple carry/borrow.
module mod_digit_cell
  import counter_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic               step,
  input  logic               dir,
  input  logic               cin,
  output logic [DIGIT_W-1:0] digit,
  output logic               cout
);

  localparam logic [DIGIT_W-1:0] MAX = DIGIT_W'(MOD - 1);

  logic at_limit;

  assign at_limit = (dir == DIR_DOWN) ? (digit == '0) : (digit == MAX);
  // cout already includes cin so the chain ripples straight through the cells.
  assign cout     = cin & at_limit;

  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_digit;
    end else if (step && cin) begin
      if (dir == DIR_DOWN)
        digit <= (digit == '0) ? MAX : digit - 1'b1;
      else
        digit <= (digit == MAX) ? '0 : digit + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// Multi-digit modulo-MOD up/down counter with load, arm FSM and wrap pulse.
// Build option: BCD_COUNTER_SATURATE_EN makes the count saturate instead of wrapping.
module bcd_updown_counter_n
  import counter_pkg::*;
#(
  parameter  int DIGITS = 2,
  parameter  int MOD    = 10,
  localparam int QW     = DIGITS * DIGIT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          dir,
  input  logic          load,
  input  logic [QW-1:0] load_val,
  output logic [QW-1:0] q,
  output logic          carry,
  output logic [1:0]    state
);

  state_t state_q;

  logic [DIGITS:0] chain;
  logic            step_req;
  logic            at_end;
  logic            step;

  assign chain[0] = 1'b1;
  assign at_end   = chain[DIGITS];
  assign step_req = en & ~load & (state_q != ST_START);

`ifdef BCD_COUNTER_SATURATE_EN
  // At the limit the digits are frozen; the attempt still reports on carry.
  assign step = step_req & ~at_end;
`else
  assign step = step_req;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    mod_digit_cell #(.MOD(MOD)) u_cell (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_digit (clamp_digit(load_val[k*DIGIT_W +: DIGIT_W], MOD)),
      .step       (step),
      .dir        (dir),
      .cin        (chain[k]),
      .digit      (q[k*DIGIT_W +: DIGIT_W]),
      .cout       (chain[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_START;
      carry   <= 1'b0;
    end else if (load) begin
      carry   <= 1'b0;
    end else if (en) begin
      state_q <= (dir == DIR_DOWN) ? ST_DOWN : ST_UP;
      carry   <= step_req & at_end;
    end else begin
      carry   <= 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Directed self-checking bench for bcd_updown_counter_n (DIGITS=2, MOD=10).
module tb_bcd_updown_counter_n;

  localparam logic [1:0] S_START = 2'b00;
  localparam logic [1:0] S_DOWN  = 2'b01;
  localparam logic [1:0] S_UP    = 2'b10;

  logic       clk = 1'b0;
  logic       reset, en, dir, load;
  logic [7:0] load_val;
  logic [7:0] q;
  logic       carry;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  bcd_updown_counter_n #(.DIGITS(2), .MOD(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .carry    (carry),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  initial begin
    reset = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    tick();
    check("rst_q", q, 8'h00);
    check("rst_carry", carry, 0);
    check("rst_state", state, S_START);

    // Full up sweep: arm cycle, 0x01..0x99, then wrap with carry.
    reset = 1'b0; en = 1'b1; dir = 1'b0;
    for (int i = 1; i <= 101; i++) begin
      tick();
      if (i == 1) begin
        check("arm_state", state, S_UP);
        check("arm_q", q, 8'h00);
      end else begin
        check("up_q", q, to_bcd((i - 1) % 100));
      end
      check("up_carry", carry, (i == 101) ? 1 : 0);
    end
    tick();
    check("post_wrap_q", q, 8'h01);
    check("post_wrap_carry", carry, 0);

    // Load with en high: loaded value only, state unchanged.
    load = 1'b1; load_val = 8'h00; dir = 1'b1;
    tick();
    check("ld_en_q", q, 8'h00);
    check("ld_en_state", state, S_UP);
    check("ld_en_carry", carry, 0);
    load = 1'b0;
    tick();
    check("dn_wrap_q", q, 8'h99);
    check("dn_wrap_carry", carry, 1);
    check("dn_state", state, S_DOWN);
    tick();
    check("dn_step_q", q, 8'h98);
    check("dn_step_carry", carry, 0);

    // Reversal around a digit boundary.
    load = 1'b1; load_val = 8'h38;
    tick();
    load = 1'b0; dir = 1'b0;
    tick();
    check("rev_q0", q, 8'h39);
    tick();
    check("rev_q1", q, 8'h40);
    check("rev_state_up", state, S_UP);
    dir = 1'b1;
    tick();
    check("rev_q2", q, 8'h39);
    check("rev_state_dn", state, S_DOWN);

    // Clamping of out-of-range digits, with en low.
    en = 1'b0; load = 1'b1; load_val = 8'hAF;
    tick();
    check("clamp_af", q, 8'h99);
    load_val = 8'h5C;
    tick();
    check("clamp_5c", q, 8'h59);
    load_val = 8'hB3;
    tick();
    check("clamp_b3", q, 8'h93);

    // Load while enabled, then step from the loaded value.
    en = 1'b1; dir = 1'b0; load_val = 8'h57;
    tick();
    check("ld57_q", q, 8'h57);
    load = 1'b0;
    tick();
    check("ld57_step", q, 8'h58);

    // Reset mid-count with en held high.
    reset = 1'b1;
    tick();
    check("mid_rst_q", q, 8'h00);
    check("mid_rst_state", state, S_START);
    reset = 1'b0;
    tick();
    check("rearm_state", state, S_UP);
    check("rearm_q", q, 8'h00);
    tick();
    check("rearm_step", q, 8'h01);

    // Down through zero, then hold with en low.
    dir = 1'b1;
    tick();
    check("dn_to_0", q, 8'h00);
    check("dn_to_0_carry", carry, 0);
    tick();
    check("dn_wrap2_q", q, 8'h99);
    check("dn_wrap2_carry", carry, 1);
    en = 1'b0;
    tick();
    check("hold_q", q, 8'h99);
    check("hold_carry", carry, 0);
    check("hold_state", state, S_DOWN);

    // Approach the top from 0x98.
    load = 1'b1; load_val = 8'h98;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b0;
    tick();
    check("top_q0", q, 8'h99);
    check("top_c0", carry, 0);
    tick();
`ifdef BCD_COUNTER_SATURATE_EN
    check("sat_q1", q, 8'h99);
    check("sat_c1", carry, 1);
    tick();
    check("sat_q2", q, 8'h99);
    check("sat_c2", carry, 1);
    dir = 1'b1;
    tick();
    check("sat_rev_q", q, 8'h98);
    check("sat_rev_c", carry, 0);
`else
    check("wrap_q1", q, 8'h00);
    check("wrap_c1", carry, 1);
    tick();
    check("wrap_q2", q, 8'h01);
    check("wrap_c2", carry, 0);
    dir = 1'b1;
    tick();
    check("wrap_rev_q", q, 8'h00);
    check("wrap_rev_c", carry, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter_n.md
Name: bcd_updown_counter_n

Overview:
- Parametrised multi-digit modulo-M up/down counter; the next generation of the single-digit decade counter.
- Chains DIGITS cells of radix MOD with ripple carry/borrow between digits.
- Adds count enable, synchronous parallel load, an explicit START/UP/DOWN direction FSM and a whole-counter wrap pulse.
- Drives multi-digit BCD displays, event tallies and timers in the homework/lab designs.

Parameters:
- DIGITS, 2, number of digit cells (1..8).
- MOD, 10, radix of each digit (2..16); each digit holds 0..MOD-1.
- localparam DIGIT_W, 4, bits per digit (fixed).
- localparam QW, DIGITS*DIGIT_W, total count width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable, sampled each rising edge.
- dir  in  1  0 = count up, 1 = count down.
- load  in  1  synchronous parallel load strobe.
- load_val  in  QW  load value; digit k at bits [4k+3:4k], digit 0 least significant.
- q  out  QW  current count, registered.
- carry  out  1  one-cycle pulse on whole-counter wrap (up or down).
- state  out  2  FSM state: START=2'b00, DOWN=2'b01, UP=2'b10.

Behaviour:
- Reset is the highest priority, synchronous. Next edge gives: q=0, carry=0, state=START. All outputs are registered; no combinational path from inputs to outputs.
- Priority order: reset > load > en.
- load=1:
  - q <= load_val, with any digit >= MOD clamped to MOD-1.
  - carry <= 0.
  - state is unchanged.
  - en is ignored that cycle.
- FSM, evaluated when en=1 and load=0:
  - START: state <= (dir ? DOWN : UP). No count step on this arming cycle (one-cycle arm latency).
  - UP/DOWN: state <= (dir ? DOWN : UP). q steps one in the direction given by the current dir, in the same cycle. A reversal costs no dead cycle.
  - en=0: q, state hold; carry <= 0.
- Up step:
  - Digit 0 increments.
  - Digit k increments only if digits 0..k-1 are all MOD-1.
  - A digit at MOD-1 that increments wraps to 0.
- Down step:
  - Digit 0 decrements.
  - Digit k decrements only if digits 0..k-1 are all 0.
  - A digit at 0 that decrements wraps to MOD-1.
- carry:
  - Up wrap: carry <= 1 on the edge where all digits are MOD-1 and step up to all 0.
  - Down wrap: carry <= 1 on the edge where all digits are 0 and step down to all MOD-1.
  - Otherwise carry <= 0. The pulse lasts exactly one cycle, coincident with the wrapped q.
- The arithmetic never produces a digit value >= MOD. Per-digit 4-bit compare only; no binary add across digit boundaries.
- Reset mid-count discards the count and state immediately; the first en after reset is an arming cycle again.
- load simultaneous with en: the loaded value appears; no step; the next en cycle steps from the loaded value.
- DIGITS=1, MOD=10 reproduces single-digit decade behaviour.

Optional Feature:
- Macro: BCD_COUNTER_SATURATE_EN.
- Defined:
  - Up saturates at all-(MOD-1); down saturates at all-0. q holds at the limit.
  - carry pulses for one cycle on each enabled step attempt past the limit.
  - Reversing direction leaves saturation immediately.
- Undefined: wrap-around behaviour as in Behaviour. The saturation logic is absent from the netlist.

Decomposition:
- Package counter_pkg:
  - State encodings ST_START, ST_UP, ST_DOWN.
  - DIR_UP=1'b0, DIR_DOWN=1'b1.
  - DIGIT_W=4.
- Sub-module mod_digit_cell (parameter MOD):
  - Inputs: clk, reset, load, load_digit, step, dir, cin.
  - Outputs: digit, cout. cout = at limit for the direction (MOD-1 up, 0 down).
- Top-level: generate-loop chaining cout into the next cin, plus the FSM, load clamp and carry logic.

Test Plan:
- Reset, then en=1 dir=0 for 101 cycles (DIGITS=2, MOD=10):
  - Cycle 1 after reset: state=UP, q=0x00.
  - q reaches 0x99 at the 100th en cycle.
  - Next cycle: q=0x00, carry=1 for exactly one cycle.
- load_val=0x00, load=1, then en=1 dir=1:
  - q=0x99, carry=1.
  - Next step: q=0x98, carry=0.
- q=0x39 counting up, then dir flips to 1 on the next en cycle:
  - Steps 0x39 -> 0x40 -> 0x39.
  - state goes UP -> DOWN with no dead cycle.
- load_val=0xAF with MOD=10 -> q=0x99 (both digits clamped).
- load and en asserted together -> loaded value only, no step.
- Reset asserted mid-count (q=0x57) with en held high:
  - q=0x00, state=START.
  - Next cycle: state=UP, q=0x00.
  - Following cycle: q=0x01.
- With BCD_COUNTER_SATURATE_EN: count up from q=0x98:
  - 0x99, then held at 0x99 with carry=1 on each further en cycle.
  - dir=1 gives 0x98.
